// File: rtl/axi_lite_master.sv
// axi_lite_master: one-outstanding AXI4-Lite master fed by a start/write/addr/wdata command port.
// Define AXI_LITE_MASTER_TIMEOUT_EN to add a watchdog that aborts a stalled transaction.
module axi_lite_master #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  start,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            resp,
    output logic                  timeout,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RVALID,
    input  logic [1:0]            RRESP,
    output logic                  RREADY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    state_t state_r;
    logic   aw_done_r;
    logic   w_done_r;
    logic   aw_hs_s;
    logic   w_hs_s;
    logic   b_hs_s;
    logic   ar_hs_s;
    logic   r_hs_s;

    assign aw_hs_s = AWVALID & AWREADY;
    assign w_hs_s  = WVALID & WREADY;
    assign b_hs_s  = BVALID & BREADY;
    assign ar_hs_s = ARVALID & ARREADY;
    assign r_hs_s  = RVALID & RREADY;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("axi_lite_master: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wdog_cnt_r;
    logic             cpl_s;
    logic             expire_s;

    // A real completion on the final allowed cycle wins over the watchdog.
    assign cpl_s    = ((state_r == WR_RESP) && b_hs_s) || ((state_r == RD_RESP) && r_hs_s);
    assign expire_s = busy && !cpl_s && (wdog_cnt_r == CNT_LAST);

    // Watchdog counter: cleared when a command is accepted, advances every busy cycle
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wdog_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            wdog_cnt_r <= {CNT_W{1'b0}};
        end else if (busy) begin
            wdog_cnt_r <= wdog_cnt_r + CNT_W'(1);
        end else begin
            wdog_cnt_r <= wdog_cnt_r;
        end
    end
`endif

    // Transaction FSM with all command-side and AXI-side outputs registered
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_r   <= IDLE;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= {DATA_WIDTH{1'b0}};
            resp      <= 2'b00;
            timeout   <= 1'b0;
            AWADDR    <= {ADDR_WIDTH{1'b0}};
            AWVALID   <= 1'b0;
            WDATA     <= {DATA_WIDTH{1'b0}};
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARADDR    <= {ADDR_WIDTH{1'b0}};
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (write) begin
                            AWADDR    <= addr;
                            WDATA     <= wdata;
                            AWVALID   <= 1'b1;
                            WVALID    <= 1'b1;
                            aw_done_r <= 1'b0;
                            w_done_r  <= 1'b0;
                            state_r   <= WR_REQ;
                        end else begin
                            ARADDR  <= addr;
                            ARVALID <= 1'b1;
                            state_r <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    // AW and W complete independently; the response phase waits for both.
                    if (aw_hs_s) begin
                        AWVALID   <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs_s) begin
                        WVALID   <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
                        BREADY  <= 1'b1;
                        state_r <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_hs_s) begin
                        resp    <= BRESP;
                        BREADY  <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (ar_hs_s) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state_r <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (r_hs_s) begin
                        rdata   <= RDATA;
                        resp    <= RRESP;
                        RREADY  <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    AWVALID <= 1'b0;
                    WVALID  <= 1'b0;
                    BREADY  <= 1'b0;
                    ARVALID <= 1'b0;
                    RREADY  <= 1'b0;
                end
            endcase
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
            if (expire_s) begin
                state_r <= IDLE;
                busy    <= 1'b0;
                AWVALID <= 1'b0;
                WVALID  <= 1'b0;
                BREADY  <= 1'b0;
                ARVALID <= 1'b0;
                RREADY  <= 1'b0;
                done    <= 1'b1;
                timeout <= 1'b1;
                resp    <= 2'b10;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Scoreboard bench for axi_lite_master: behavioural register-slave, reference model queue and done monitor.
module tb_axi_lite_master;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          ACLK, ARESETn, start, write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          busy, done, timeout;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic [AW-1:0] AWADDR, ARADDR;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0] WDATA, RDATA;
    logic [1:0]    BRESP, RRESP;

    axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .write(write), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .resp(resp), .timeout(timeout),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RRESP(RRESP), .RREADY(RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    typedef struct {
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        logic          tmo;
    } exp_t;

    exp_t          expq[$];
    int            n_pass = 0;
    int            n_total = 0;
    logic [DW-1:0] ref_mem [4];
    logic [DW-1:0] last_rdata;
    int            cyc = 0;
    int            acc_cyc;

    // Slave wait cycles per channel; -1 means never respond.
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    endtask

    always @(posedge ACLK) cyc <= cyc + 1;

    // Behavioural AXI-Lite slave: 4 word registers, misaligned access gets SLVERR and no write.
    // Decisions are made at the falling edge for the handshake at the next rising edge.
    initial begin : slave
        logic [DW-1:0] slv_mem [4];
        logic          aw_got, w_got, ar_got, b_pend, r_pend, b_fire, r_fire;
        logic [AW-1:0] aw_a, ar_a;
        logic [DW-1:0] w_d;
        int            aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        for (int i = 0; i < 4; i++) slv_mem[i] = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
        aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0; b_fire = 0; r_fire = 0;
        aw_a = '0; ar_a = '0; w_d = '0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;
                aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0; b_fire = 0; r_fire = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            end else begin
                if (b_fire) begin BVALID = 1'b0; b_pend = 0; aw_got = 0; w_got = 0; b_fire = 0; end
                if (r_fire) begin RVALID = 1'b0; r_pend = 0; ar_got = 0; r_fire = 0; end
                if (aw_got && w_got && !b_pend) begin
                    if (aw_a[1:0] == 2'b00) slv_mem[aw_a[3:2]] = w_d;
                    BRESP = (aw_a[1:0] != 2'b00) ? 2'b10 : 2'b00;
                    b_pend = 1; b_cnt = 0;
                end
                if (ar_got && !r_pend) begin
                    RDATA = slv_mem[ar_a[3:2]];
                    RRESP = (ar_a[1:0] != 2'b00) ? 2'b10 : 2'b00;
                    r_pend = 1; r_cnt = 0;
                end
                AWREADY = 1'b0;
                if (AWVALID && !aw_got) begin
                    if (aw_dly >= 0 && aw_cnt >= aw_dly) begin
                        AWREADY = 1'b1; aw_got = 1; aw_a = AWADDR; aw_cnt = 0;
                    end else aw_cnt++;
                end else aw_cnt = 0;
                WREADY = 1'b0;
                if (WVALID && !w_got) begin
                    if (w_dly >= 0 && w_cnt >= w_dly) begin
                        WREADY = 1'b1; w_got = 1; w_d = WDATA; w_cnt = 0;
                    end else w_cnt++;
                end else w_cnt = 0;
                ARREADY = 1'b0;
                if (ARVALID && !ar_got) begin
                    if (ar_dly >= 0 && ar_cnt >= ar_dly) begin
                        ARREADY = 1'b1; ar_got = 1; ar_a = ARADDR; ar_cnt = 0;
                    end else ar_cnt++;
                end else ar_cnt = 0;
                if (b_pend && !BVALID) begin
                    if (b_dly >= 0 && b_cnt >= b_dly) BVALID = 1'b1;
                    else b_cnt++;
                end
                if (r_pend && !RVALID) begin
                    if (r_dly >= 0 && r_cnt >= r_dly) RVALID = 1'b1;
                    else r_cnt++;
                end
                b_fire = BVALID && BREADY;
                r_fire = RVALID && RREADY;
            end
        end
    end

    // Monitor: every done pulse consumes one scoreboard entry
    always @(negedge ACLK) begin
        if (ARESETn && done) begin
            if (expq.size() == 0) begin
                chk("unexpected_done", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("resp", resp, e.resp);
                chk("timeout_flag", timeout, e.tmo);
                chk("busy_at_done", busy, 1'b0);
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            @(negedge ACLK);
            k++;
        end
        chk("wait_idle", busy, 1'b0);
    endtask

    // Issue a command at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic exp_to);
        exp_t e;
        wait_idle();
        start = 1'b1; write = w; addr = a; wdata = d;
        e.tmo = exp_to;
        if (exp_to) begin
            e.resp = 2'b10; e.rdata = last_rdata;
        end else begin
            e.resp = (a[1:0] != 2'b00) ? 2'b10 : 2'b00;
            if (w) begin
                if (a[1:0] == 2'b00) ref_mem[a[3:2]] = d;
                e.rdata = last_rdata;
            end else begin
                e.rdata = ref_mem[a[3:2]];
                last_rdata = e.rdata;
            end
        end
        expq.push_back(e);
        @(posedge ACLK);
        @(negedge ACLK);
        acc_cyc = cyc;
        start = 1'b0; write = 1'($urandom); addr = AW'($urandom); wdata = $urandom;
    endtask

    task automatic set_dly(input int a, input int wd, input int b, input int ar, input int r);
        aw_dly = a; w_dly = wd; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk(nm, {busy, done, rdata, resp, timeout, AWADDR, AWVALID, WDATA, WVALID, BREADY,
                 ARADDR, ARVALID, RREADY}, 128'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int k;
        int t0;
        logic ok;
        logic seen;
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        last_rdata = '0;
        ARESETn = 1'b0; start = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge ACLK);
        check_reset_outputs("reset_state");
        ARESETn = 1'b1;
        @(negedge ACLK);

        // Zero-wait write then read: VALID in N+1, READY in N+2, done in N+3
        set_dly(0, 0, 0, 0, 0);
        issue(1'b1, 4'h8, 32'hA5A5_0001, 1'b0);
        chk("zw_wr_n1", {AWVALID, WVALID, busy, BREADY}, 4'b1110);
        chk("zw_wr_awaddr", {AWADDR, WDATA}, {4'h8, 32'hA5A5_0001});
        @(negedge ACLK);
        chk("zw_wr_n2", {AWVALID, WVALID, BREADY}, 3'b001);
        @(negedge ACLK);
        chk("zw_wr_n3", {done, busy}, 2'b10);
        issue(1'b0, 4'h8, 32'h0, 1'b0);
        chk("zw_rd_n1", {ARVALID, ARADDR, RREADY}, {1'b1, 4'h8, 1'b0});
        @(negedge ACLK);
        chk("zw_rd_n2", {ARVALID, RREADY}, 2'b01);
        @(negedge ACLK);
        chk("zw_rd_n3", {done, busy}, 2'b10);

        // READY one cycle late on both AW and W
        set_dly(1, 1, 0, 0, 0);
        issue(1'b1, 4'h4, 32'hDEAD_BEEF, 1'b0);
        @(negedge ACLK);
        chk("late_hold", {AWVALID, WVALID, BREADY}, 3'b110);
        @(negedge ACLK);
        chk("late_bready", {AWVALID, WVALID, BREADY}, 3'b001);
        set_dly(0, 0, 0, 0, 0);
        issue(1'b0, 4'h4, 32'h0, 1'b0);

        // W three cycles after AW, plus an ignored start while busy
        set_dly(0, 3, 0, 0, 0);
        issue(1'b1, 4'hC, 32'h1234_5678, 1'b0);
        @(negedge ACLK);
        chk("skew_aw_dropped", {AWVALID, WVALID, BREADY}, 3'b010);
        start = 1'b1; write = 1'b0; addr = 4'h0;
        @(negedge ACLK);
        start = 1'b0;
        k = 0;
        while (!BREADY && k < 20) begin @(negedge ACLK); k++; end
        chk("skew_bready_after_w", {BREADY, WVALID, AWVALID}, 3'b100);
        wait_idle();
        repeat (3) @(negedge ACLK);
        chk("busy_start_ignored", busy, 1'b0);

        // RVALID four cycles late; RREADY must hold throughout
        set_dly(0, 0, 0, 0, 4);
        issue(1'b0, 4'hC, 32'h0, 1'b0);
        @(negedge ACLK);
        ok = 1'b1; k = 0;
        while (!done && k < 20) begin
            ok = ok & RREADY;
            @(negedge ACLK);
            k++;
        end
        chk("rready_held", {ok, done}, 2'b11);

        // Randomized traffic with 0/1 wait cycles per channel
        for (int n = 0; n < 40; n++) begin
            set_dly($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1));
            issue(1'($urandom), AW'($urandom), $urandom, 1'b0);
        end
        wait_idle();

        // Back-to-back zero-wait throughput: one transaction per 3 cycles
        set_dly(0, 0, 0, 0, 0);
        issue(1'b1, 4'h0, 32'h0BAD_F00D, 1'b0);
        t0 = acc_cyc;
        issue(1'b0, 4'h0, 32'h0, 1'b0);
        chk("b2b_spacing", acc_cyc - t0, 3);

        // Reset while waiting in WR_RESP
        set_dly(0, 0, -1, 0, 0);
        issue(1'b1, 4'h0, 32'hCAFE_0042, 1'b0);
        k = 0;
        while (!BREADY && k < 20) begin @(negedge ACLK); k++; end
        chk("reached_wr_resp", BREADY, 1'b1);
        @(negedge ACLK);
        ARESETn = 1'b0;
        expq.delete();
        last_rdata = '0;
        @(negedge ACLK);
        check_reset_outputs("midreset_outputs");
        @(negedge ACLK);
        ARESETn = 1'b1;
        set_dly(0, 0, 0, 0, 0);
        seen = 1'b0;
        repeat (5) begin @(negedge ACLK); seen = seen | done | busy; end
        chk("no_done_after_reset", seen, 1'b0);
        issue(1'b0, 4'h0, 32'h0, 1'b0);
        wait_idle();

        // Slave never asserts ARREADY
        set_dly(0, 0, 0, -1, 0);
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        issue(1'b0, 4'h4, 32'h0, 1'b1);
        k = 1;
        while (!done && k < 30) begin @(negedge ACLK); k++; end
        chk("timeout_latency", k, TO + 1);
        chk("timeout_valid_dropped", {ARVALID, RREADY, busy}, 3'b000);
        set_dly(0, 0, 0, 0, 0);
        issue(1'b0, 4'h4, 32'h0, 1'b0);
`else
        issue(1'b0, 4'h4, 32'h0, 1'b0);
        expq.delete();
        seen = 1'b0;
        repeat (20) begin @(negedge ACLK); seen = seen | done; end
        chk("stall_busy_held", {busy, ARVALID, seen, timeout}, 4'b1100);
        ARESETn = 1'b0;
        last_rdata = '0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        set_dly(0, 0, 0, 0, 0);
        issue(1'b0, 4'h4, 32'h0, 1'b0);
`endif
        wait_idle();
        repeat (3) @(negedge ACLK);
        chk("queue_drained", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
